// File: rtl/display_pkg.sv
// Shared types and constants for the display character feeder.
package display_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2
    } feeder_state_t;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with first-word-fall-through head and synchronous flush.
module sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             wr_ok;
    logic             rd_ok;

    // Full refuses a write even when a pop frees a slot in the same cycle.
    assign wr_ok = push && !full;
    assign rd_ok = pop && !empty;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
            if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
            if (wr_ok && !rd_ok)      count <= count + 1'b1;
            else if (!wr_ok && rd_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_ok && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/display_char_feeder.sv
// Buffers bus-written characters and paces them to the display as one-cycle strobes.
//   state | meaning
//   IDLE  | nothing in flight; pop and pulse as soon as the FIFO has data
//   EMIT  | displayEn_o high for this single cycle
//   GAP   | enforced low time after a pulse; counter runs down to 0
module display_char_feeder
    import display_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int GAP_CYCLES = 5,
    parameter int CHAR_W     = display_pkg::CHAR_W
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [CHAR_W-1:0]          char_i,
    input  logic                       charValid_i,
    output logic                       charReady_o,
    input  logic                       flush_i,
    output logic [CHAR_W-1:0]          hex_o,
    output logic                       displayEn_o,
    output logic                       busy_o,
    output logic [$clog2(DEPTH+1)-1:0] level_o
);

    localparam int CNT_W = $clog2(GAP_CYCLES + 1);

    feeder_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CHAR_W-1:0] hex_q, hex_d;
    logic              en_q, en_d;

    logic              fifo_full;
    logic              fifo_empty;
    logic [CHAR_W-1:0] fifo_head;
    logic              pop;
    logic              can_emit;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CHAR_W)
    ) u_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .flush  (flush_i),
        .push   (charValid_i && !flush_i),
        .wdata  (char_i),
        .pop    (pop),
        .rdata  (fifo_head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level_o)
    );

    assign can_emit = !fifo_empty && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hex_q   <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hex_q   <= hex_d;
            en_q    <= en_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (can_emit) state_d = EMIT;
            EMIT:    state_d = GAP;
            GAP:     if (cnt_q == '0) state_d = can_emit ? EMIT : IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_comb begin
        pop   = can_emit && ((state_q == IDLE) || ((state_q == GAP) && (cnt_q == '0)));
        cnt_d = cnt_q;
        if (state_q == EMIT)
            cnt_d = CNT_W'(GAP_CYCLES - 1);
        else if ((state_q == GAP) && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
        // hex holds the last character shown; only flush or reset clear it.
        hex_d = pop ? fifo_head : hex_q;
        en_d  = pop;
        if (flush_i) begin
            cnt_d = '0;
            hex_d = '0;
        end
    end

    assign hex_o       = hex_q;
    assign displayEn_o = en_q;
    assign charReady_o = !fifo_full;
    assign busy_o      = (level_o != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_display_char_feeder.sv
// Randomized and directed stimulus against a queue-and-timestamp reference model.
module tb_display_char_feeder;
    import display_pkg::*;

    localparam int DEPTH = 16;
    localparam int G     = 5;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic [7:0]    char_i = '0;
    logic          charValid_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          charReady_o;
    logic [7:0]    hex_o;
    logic          displayEn_o;
    logic          busy_o;
    logic [LW-1:0] level_o;

    display_char_feeder #(
        .DEPTH      (DEPTH),
        .GAP_CYCLES (G),
        .CHAR_W     (8)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .char_i      (char_i),
        .charValid_i (charValid_i),
        .charReady_o (charReady_o),
        .flush_i     (flush_i),
        .hex_o       (hex_o),
        .displayEn_o (displayEn_o),
        .busy_o      (busy_o),
        .level_o     (level_o)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // Reference model: FIFO contents, last shown character, edge of last pulse.
    logic [7:0] mq[$];
    logic [7:0] m_hex = '0;
    logic       m_en = 1'b0;
    int         ecnt = 0;
    int         last = -1000;
    int         pulses[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, ecnt);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_hex = '0;
        m_en  = 1'b0;
        last  = -1000;
    endtask

    task automatic check_outputs();
        chk("hex", 32'(hex_o), 32'(m_hex));
        chk("en", 32'(displayEn_o), 32'(m_en));
        chk("level", 32'(level_o), 32'(mq.size()));
        chk("busy", 32'(busy_o), 32'((mq.size() != 0) || (ecnt - last <= G)));
    endtask

    // Drive one cycle of inputs, advance the model across the edge, check after it.
    task automatic step(input logic v, input logic [7:0] c, input logic f);
        int  e;
        bit  pop_e, push_e;
        char_i      = c;
        charValid_i = v;
        flush_i     = f;
        chk("ready", 32'(charReady_o), 32'(mq.size() < DEPTH));
        e      = ecnt + 1;
        pop_e  = !f && (mq.size() != 0) && (e - last >= G + 1);
        push_e = v && !f && (mq.size() < DEPTH);
        @(posedge clk_i);
        ecnt = e;
        if (f) begin
            model_reset();
        end else begin
            m_en = pop_e;
            if (pop_e) begin
                m_hex = mq.pop_front();
                last  = e;
            end
            if (push_e) mq.push_back(c);
        end
        @(negedge clk_i);
        if (displayEn_o) pulses.push_back(ecnt);
        check_outputs();
    endtask

    logic [7:0] hello [11] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F, ASCII_SPACE,
                               8'h77, 8'h6F, 8'h72, 8'h6C, 8'h64};

    initial begin
        int guard;
        // Reset values while held in reset.
        #12;
        chk("rst_ready", 32'(charReady_o), 32'd1);
        check_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single character, then let it drain well past the gap.
        step(1'b1, 8'h68, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b0);

        // Back-to-back burst: pacing and ordering.
        pulses.delete();
        for (int i = 0; i < 11; i++) step(1'b1, hello[i], 1'b0);
        for (int i = 0; i < 70; i++) step(1'b0, 8'h00, 1'b0);
        chk("burst_count", 32'(pulses.size()), 32'd11);
        for (int i = 1; i < pulses.size(); i++)
            chk("burst_spacing", 32'(pulses[i] - pulses[i-1]), 32'(G + 1));

        // Overfill: refused writes and full with simultaneous pop.
        for (int i = 0; i < 40; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
        for (int i = 0; i < 110; i++) step(1'b0, 8'h00, 1'b0);

        // Flush during a gap with characters queued, concurrent write dropped.
        for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h41 + i), 1'b0);
        step(1'b1, 8'h7A, 1'b1);
        chk("flush_level", 32'(level_o), 32'd0);
        chk("flush_hex", 32'(hex_o), 32'd0);
        pulses.delete();
        for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0);
        chk("flush_no_pulse", 32'(pulses.size()), 32'd0);

        // Asynchronous reset in the middle of an EMIT cycle.
        step(1'b1, 8'h55, 1'b0);
        guard = 0;
        while (!displayEn_o && guard < 20) begin
            step(1'b1, 8'h56, 1'b0);
            guard++;
        end
        chk("emit_seen", 32'(displayEn_o), 32'd1);
        charValid_i = 1'b0;
        #1 rst_ni = 1'b0;
        #1;
        model_reset();
        chk("arst_en", 32'(displayEn_o), 32'd0);
        chk("arst_ready", 32'(charReady_o), 32'd1);
        check_outputs();
        @(negedge clk_i);
        rst_ni = 1'b1;
        step(1'b1, 8'h42, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0);

        // Random traffic with varying write density and occasional flush.
        for (int blk = 0; blk < 8; blk++) begin
            int dens;
            dens = $urandom_range(10, 100);
            for (int i = 0; i < 100; i++)
                step(($urandom_range(99) < dens), 8'($urandom),
                     ($urandom_range(63) == 0));
        end
        for (int i = 0; i < 120; i++) step(1'b0, 8'h00, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
